// File: rtl/udp_status_pkg.sv
// Shared types and constants for the board-to-host UDP status packet path.
package udp_status_pkg;

  localparam int unsigned PKT_LEN    = 8;
  localparam int unsigned KEY_W      = 4;
  localparam int unsigned SW_W       = 8;
  localparam int unsigned VEC_W      = KEY_W + SW_W;
  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned BYTE_IDX_W = 3;

  localparam logic [3:0] PKT_TYPE_STATUS = 4'hA;

  localparam logic [BYTE_IDX_W-1:0] B_TYPE   = 3'd0;
  localparam logic [BYTE_IDX_W-1:0] B_SW     = 3'd1;
  localparam logic [BYTE_IDX_W-1:0] B_SEQ_HI = 3'd2;
  localparam logic [BYTE_IDX_W-1:0] B_SEQ_LO = 3'd3;
  localparam logic [BYTE_IDX_W-1:0] B_FLAGS  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Packet contents frozen when a request is raised
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [SW_W-1:0]  sw;
    logic [SEQ_W-1:0] seq;
    logic             hb;
  } snap_t;

  function automatic logic [7:0] pkt_byte(snap_t s, logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      B_TYPE:   b = {s.key, PKT_TYPE_STATUS};
      B_SW:     b = s.sw;
      B_SEQ_HI: b = s.seq[15:8];
      B_SEQ_LO: b = s.seq[7:0];
      B_FLAGS:  b = {7'd0, s.hb};
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_status_sync.sv
// Two-flop synchroniser for {key,sw} with a registered change pulse.
// The change pulse is held off until both stages carry real input data after reset.
module udp_status_sync
  import udp_status_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VEC_W-1:0] async_i,
  output logic [VEC_W-1:0] sync_vec_o,
  output logic             change_o
);

  logic [VEC_W-1:0] s1_q;
  logic [VEC_W-1:0] s2_q;
  logic [1:0]       prime_q;
  logic             change_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prime_q  <= 2'b00;
      change_q <= 1'b0;
    end else begin
      s1_q     <= async_i;
      s2_q     <= s1_q;
      prime_q  <= {prime_q[0], 1'b1};
      change_q <= prime_q[1] & (s1_q != s2_q);
    end
  end

  assign sync_vec_o = s2_q;
  assign change_o   = change_q;

endmodule

// File: rtl/udp_status_tx.sv
// Samples keys/switches and streams an 8-byte status packet to the UDP stack app_tx port.
// Optional heartbeat packets are enabled by defining UDP_STATUS_HEARTBEAT_EN.
module udp_status_tx
  import udp_status_pkg::*;
#(
  parameter logic [15:0] ACK_TIMEOUT      = 16'd4096,
  parameter logic [7:0]  GAP_CYCLES       = 8'd16,
  parameter logic [31:0] HEARTBEAT_CYCLES = 32'd125000000
) (
  input  logic        udp_tx_clk,
  input  logic        reset,
  input  logic [3:0]  key_in,
  input  logic [7:0]  sw_in,
  output logic        app_tx_data_request,
  input  logic        app_tx_ack,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_tx_data_length,
  output logic        tx_busy
);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             pending_q, pending_d;
  logic             hb_flag_q, hb_flag_d;
  snap_t            snap_q, snap_d;
  logic             request_q, request_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      length_q, length_d;
  logic             busy_q, busy_d;

  logic [VEC_W-1:0] sync_vec;
  logic             change_c;
  logic             hb_tick_c;
  logic             pend_set_c;
  logic             pend_clr_c;

  udp_status_sync u_sync (
    .clk        (udp_tx_clk),
    .rst_n      (reset),
    .async_i    ({key_in, sw_in}),
    .sync_vec_o (sync_vec),
    .change_o   (change_c)
  );

`ifdef UDP_STATUS_HEARTBEAT_EN
  logic [31:0] hb_cnt_q;

  // Free-running heartbeat period counter
  always_ff @(posedge udp_tx_clk or negedge reset) begin
    if (!reset) begin
      hb_cnt_q <= 32'd0;
    end else if (hb_cnt_q == HEARTBEAT_CYCLES - 32'd1) begin
      hb_cnt_q <= 32'd0;
    end else begin
      hb_cnt_q <= hb_cnt_q + 32'd1;
    end
  end

  assign hb_tick_c = (hb_cnt_q == HEARTBEAT_CYCLES - 32'd1);
`else
  // No heartbeat in this build; the period is referenced only to keep it declared
  assign hb_tick_c = 1'b0 && (HEARTBEAT_CYCLES == 32'd0);
`endif

  always_ff @(posedge udp_tx_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      hb_flag_q <= 1'b0;
      snap_q    <= '0;
      request_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      length_q  <= 16'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      hb_flag_q <= hb_flag_d;
      snap_q    <= snap_d;
      request_q <= request_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      length_q  <= length_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and registered-output logic; cnt_q is reused as timeout, byte and gap counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    snap_d     = snap_q;
    hb_flag_d  = hb_flag_q | hb_tick_c;
    pend_set_c = change_c | hb_tick_c;
    pend_clr_c = 1'b0;
    valid_d    = 1'b0;
    data_d     = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d    = ST_REQ;
          cnt_d      = 16'd0;
          pend_clr_c = 1'b1;
          snap_d.key = sync_vec[VEC_W-1:SW_W];
          snap_d.sw  = sync_vec[SW_W-1:0];
          snap_d.seq = seq_q;
          snap_d.hb  = hb_flag_q;
        end
      end
      ST_REQ: begin
        if (app_tx_ack) begin
          state_d = ST_SEND;
          cnt_d   = 16'd1;
          valid_d = 1'b1;
          data_d  = pkt_byte(snap_q, B_TYPE);
          if (snap_q.hb && !hb_tick_c) begin
            hb_flag_d = 1'b0;
          end
        end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
          // Abandon this request; a fresh one with the same seq follows
          state_d    = ST_IDLE;
          pend_set_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SEND: begin
        if (cnt_q == 16'(PKT_LEN)) begin
          state_d = ST_GAP;
          cnt_d   = 16'd0;
          seq_d   = seq_q + 16'd1;
        end else begin
          valid_d = 1'b1;
          data_d  = pkt_byte(snap_q, cnt_q[BYTE_IDX_W-1:0]);
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(GAP_CYCLES) - 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (pending_q & ~pend_clr_c) | pend_set_c;
    request_d = (state_d == ST_REQ);
    length_d  = request_d ? 16'(PKT_LEN) : 16'd0;
    busy_d    = (state_d != ST_IDLE);
  end

  assign app_tx_data_request = request_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data         = data_q;
  assign udp_tx_data_length  = length_q;
  assign tx_busy             = busy_q;

endmodule

// File: tb/tb_udp_status_tx.sv
// Directed self-checking bench for udp_status_tx (ack timeout 20, gap 16, heartbeat 100).
module tb_udp_status_tx;

  localparam logic [15:0] TMO = 16'd20;
  localparam logic [7:0]  GAP = 8'd16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key   = 4'h0;
  logic [7:0]  sw    = 8'h00;
  logic        ack   = 1'b0;
  logic        req;
  logic        valid;
  logic [7:0]  data;
  logic [15:0] len;
  logic        busy;

  int total = 0;
  int bad   = 0;

  udp_status_tx #(
    .ACK_TIMEOUT      (TMO),
    .GAP_CYCLES       (GAP),
    .HEARTBEAT_CYCLES (32'd100)
  ) dut (
    .udp_tx_clk          (clk),
    .reset               (rst_n),
    .key_in              (key),
    .sw_in               (sw),
    .app_tx_data_request (req),
    .app_tx_ack          (ack),
    .app_tx_data_valid   (valid),
    .app_tx_data         (data),
    .udp_tx_data_length  (len),
    .tx_busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input int limit, output int waited);
    waited = 0;
    while (req !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(req), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic count_req(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (req === 1'b1) seen++;
    end
  endtask

  // Waits for a request, acks after ack_dly cycles, captures and checks all 8 bytes
  task automatic run_pkt(input string name, input int ack_dly, input bit burst,
                         input logic [63:0] exp, output int waited);
    int nv = 0;
    logic [63:0] got = '0;
    wait_req(300, waited);
    chk({name, "_len"}, 32'(len), 32'd8);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (valid === 1'b1) nv++;
      got = {got[55:0], data};
      if (burst && i == 1) key = 4'h1;
      if (burst && i == 3) key = 4'h6;
      if (burst && i == 5) key = 4'h9;
      @(negedge clk);
    end
    chk({name, "_valid_run"}, 32'(nv), 32'd8);
    chk({name, "_valid_end"}, 32'(valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_b%0d", name, i), 32'(got[63-8*i -: 8]), 32'(exp[63-8*i -: 8]));
    end
  endtask

  initial begin
    int w;
    int n;
    int m;
    logic [63:0] got4;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    count_req(10, n);
    chk("post_rst_quiet", 32'(n), 32'd0);

    // 1: switch change -> one packet, seq 0
    sw = 8'h5A;
    run_pkt("t1", 2, 1'b0, 64'h0A5A_0000_0000_0000, w);

    // 2: no ack -> request held ACK_TIMEOUT cycles, one idle cycle, retry with same seq
    wait_idle();
    sw = 8'h3C;
    wait_req(300, w);
    n = 0;
    while (req === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t2_req_high", 32'(n), 32'(TMO));
    m = 0;
    while (req !== 1'b1 && m < 100) begin
      @(negedge clk);
      m++;
    end
    chk("t2_req_low", 32'(m), 32'd1);
    run_pkt("t2", 0, 1'b0, 64'h0A3C_0001_0000_0000, w);

    // 3: three key changes during SEND -> exactly one follow-up after the gap
    wait_idle();
    sw = 8'h81;
    run_pkt("t3", 1, 1'b1, 64'h0A81_0002_0000_0000, w);
    run_pkt("t3b", 0, 1'b0, 64'h9A81_0003_0000_0000, w);
    chk("t3_gap", 32'(w), 32'(GAP) + 32'd1);
    wait_idle();
    count_req(80, n);
    chk("t3_no_extra", 32'(n), 32'd0);

    // 4: sequence wrap
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    sw = 8'h02;
    run_pkt("t4a", 1, 1'b0, 64'h9A02_FFFF_0000_0000, w);
    wait_idle();
    sw = 8'h03;
    run_pkt("t4b", 1, 1'b0, 64'h9A03_0000_0000_0000, w);

    // 5: reset at byte 4 of SEND
    wait_idle();
    sw = 8'h44;
    wait_req(300, w);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    got4 = '0;
    for (int i = 0; i < 4; i++) begin
      got4 = {got4[55:0], data};
      @(negedge clk);
    end
    chk("t5_b0_3", got4[31:0], 32'h9A44_0001);
    chk("t5_valid_b4", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_data", 32'(data), 32'd0);
    chk("t5_rst_req", 32'(req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_req(60, n);
    chk("t5_quiet", 32'(n), 32'd0);
    chk("t5_valid_quiet", 32'(valid), 32'd0);
    sw = 8'h45;
    run_pkt("t5", 1, 1'b0, 64'h9A45_0000_0000_0000, w);

    // 6: static inputs
    wait_idle();
`ifdef UDP_STATUS_HEARTBEAT_EN
    run_pkt("t6_hb", 1, 1'b0, 64'h9A45_0001_0100_0000, w);
`else
    count_req(300, n);
    chk("t6_no_hb", 32'(n), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
